shot_countdown_timer: RTL and testbench

- Consumes the registered single-cycle one-second tick from the slow-clock counter and runs a 0..99 s BCD countdown, used as the shot clock between cue strikes.
- Drives two BCD digits to the score/digit display path.
- Raises expiry outputs that the game-control FSM uses to forfeit the turn.
- Sits directly downstream of the one-second tick generator in the same clock domain.

---
 rtl/shot_countdown_timer.sv | 197 +++++++++++++++++++
 tb/tb_shot_countdown_timer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/shot_countdown_timer.sv
// shot_countdown_timer: 0..99 s BCD shot clock driven by a one-second tick.
// The optional blinking low-time warning is built only when the macro
// COUNTDOWN_WARN_EN is defined; otherwise the warn port is tied low.
module shot_countdown_timer #(
  parameter int unsigned START_VAL   = 30,
  parameter int unsigned WARN_THRESH = 5
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       one_sec,
  input  logic       load,
  input  logic [6:0] load_val,
  input  logic       start,
  input  logic       pause,
  output logic [3:0] tens,
  output logic [3:0] units,
  output logic       running,
  output logic       expired,
  output logic       timeout_pulse,
  output logic       warn
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_PAUSED,
    ST_EXPIRED
  } state_t;

  localparam logic [3:0] START_TENS  = 4'(START_VAL / 10);
  localparam logic [3:0] START_UNITS = 4'(START_VAL % 10);

  // Reject parameter values the digit path cannot represent.
  if (START_VAL < 1 || START_VAL > 99 || WARN_THRESH > 99) begin : g_param_check
    $error("shot_countdown_timer: START_VAL must be 1..99 and WARN_THRESH 0..99");
  end

  state_t     state_q, state_d;
  logic [3:0] tens_q, tens_d;
  logic [3:0] units_q, units_d;
  logic       running_q, running_d;
  logic       expired_q, expired_d;
  logic       timeout_pulse_q, timeout_pulse_d;

  logic [6:0] load_sat;
  logic [3:0] load_tens;
  logic [3:0] load_units;
  logic [3:0] dec_tens;
  logic [3:0] dec_units;
  logic       dec_zero;
  logic       cur_zero;

  // Saturate the binary load value at 99 and split it into BCD digits.
  always_comb begin
    load_sat   = (load_val > 7'd99) ? 7'd99 : load_val;
    load_tens  = 4'(load_sat / 7'd10);
    load_units = 4'(load_sat % 7'd10);
  end

  // One-second BCD decrement of the current digits, clamped at 00.
  always_comb begin
    if (units_q != 4'd0) begin
      dec_tens  = tens_q;
      dec_units = units_q - 4'd1;
    end else if (tens_q != 4'd0) begin
      dec_tens  = tens_q - 4'd1;
      dec_units = 4'd9;
    end else begin
      dec_tens  = 4'd0;
      dec_units = 4'd0;
    end
    cur_zero = (tens_q == 4'd0) && (units_q == 4'd0);
    dec_zero = (dec_tens == 4'd0) && (dec_units == 4'd0);
  end

  // Next-state and next-digit logic; load beats pause beats start beats tick.
  always_comb begin
    state_d         = state_q;
    tens_d          = tens_q;
    units_d         = units_q;
    timeout_pulse_d = 1'b0;
    if (load) begin
      state_d = ST_IDLE;
      tens_d  = load_tens;
      units_d = load_units;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!pause && start) begin
            if (cur_zero) begin
              state_d         = ST_EXPIRED;
              timeout_pulse_d = 1'b1;
            end else begin
              state_d = ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (pause) begin
            state_d = ST_PAUSED;
          end else if (one_sec) begin
            if (cur_zero || dec_zero) begin
              state_d         = ST_EXPIRED;
              tens_d          = 4'd0;
              units_d         = 4'd0;
              timeout_pulse_d = 1'b1;
            end else begin
              tens_d  = dec_tens;
              units_d = dec_units;
            end
          end
        end
        ST_PAUSED: begin
          if (!pause && start) begin
            state_d = ST_RUN;
          end
        end
        ST_EXPIRED: begin
          tens_d  = 4'd0;
          units_d = 4'd0;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
    running_d = (state_d == ST_RUN);
    expired_d = (state_d == ST_EXPIRED);
  end

  // Register state, digits and status outputs; reset restores the start value.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q         <= ST_IDLE;
      tens_q          <= START_TENS;
      units_q         <= START_UNITS;
      running_q       <= 1'b0;
      expired_q       <= 1'b0;
      timeout_pulse_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      tens_q          <= tens_d;
      units_q         <= units_d;
      running_q       <= running_d;
      expired_q       <= expired_d;
      timeout_pulse_q <= timeout_pulse_d;
    end
  end

  assign tens          = tens_q;
  assign units         = units_q;
  assign running       = running_q;
  assign expired       = expired_q;
  assign timeout_pulse = timeout_pulse_q;

`ifdef COUNTDOWN_WARN_EN
  localparam logic [6:0] WARN_LIMIT = 7'(WARN_THRESH);

  logic       warn_q, warn_d;
  logic [6:0] cur_bin;
  logic [6:0] dec_bin;
  logic       cur_in_win;
  logic       dec_in_win;

  // Warning blinks once per tick while RUN sits inside the low-time window.
  always_comb begin
    cur_bin    = 7'(tens_q) * 7'd10 + 7'(units_q);
    dec_bin    = 7'(dec_tens) * 7'd10 + 7'(dec_units);
    cur_in_win = !cur_zero && (cur_bin <= WARN_LIMIT);
    dec_in_win = !dec_zero && (dec_bin <= WARN_LIMIT);
    warn_d     = 1'b0;
    if (state_d == ST_RUN) begin
      if (state_q != ST_RUN) begin
        warn_d = cur_in_win;
      end else if (one_sec) begin
        warn_d = dec_in_win ? (cur_in_win ? ~warn_q : 1'b1) : 1'b0;
      end else begin
        warn_d = warn_q;
      end
    end
  end

  // Register the warning output.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      warn_q <= 1'b0;
    end else begin
      warn_q <= warn_d;
    end
  end

  assign warn = warn_q;
`else
  assign warn = 1'b0;
`endif

endmodule

// File: tb/tb_shot_countdown_timer.sv
// Testbench for shot_countdown_timer: directed scenarios followed by a
// randomized phase, all checked against a seconds-level reference model.
module tb_shot_countdown_timer;

  localparam int START_VAL   = 30;
  localparam int WARN_THRESH = 5;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic       one_sec = 1'b0;
  logic       load = 1'b0;
  logic [6:0] load_val = 7'd0;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic [3:0] tens;
  logic [3:0] units;
  logic       running;
  logic       expired;
  logic       timeout_pulse;
  logic       warn;

  int tests = 0;
  int fails = 0;

  typedef enum {M_IDLE, M_RUN, M_PAUSED, M_EXPIRED} mstate_t;
  mstate_t m_state;
  int      m_val;
  bit      m_pulse;
  bit      m_warn;
  bit      warn_en;
  int      pulse_seen;
  int      last_tick;
  int      cycle;

  always #5 clk = ~clk;

  shot_countdown_timer #(
    .START_VAL  (START_VAL),
    .WARN_THRESH(WARN_THRESH)
  ) dut (
    .clk          (clk),
    .resetN       (resetN),
    .one_sec      (one_sec),
    .load         (load),
    .load_val     (load_val),
    .start        (start),
    .pause        (pause),
    .tens         (tens),
    .units        (units),
    .running      (running),
    .expired      (expired),
    .timeout_pulse(timeout_pulse),
    .warn         (warn)
  );

  // Reference model: whole seconds and a coarse game state, advanced once per edge.
  task automatic modelStep(input bit rst_n, input bit ld, input int lv,
                           input bit st, input bit ps, input bit tk);
    m_pulse = 1'b0;
    if (!rst_n) begin
      m_state = M_IDLE;
      m_val   = START_VAL;
      m_warn  = 1'b0;
    end else if (ld) begin
      m_state = M_IDLE;
      m_val   = (lv > 99) ? 99 : lv;
      m_warn  = 1'b0;
    end else begin
      case (m_state)
        M_IDLE: begin
          if (!ps && st) begin
            if (m_val == 0) begin
              m_state = M_EXPIRED;
              m_pulse = 1'b1;
            end else begin
              m_state = M_RUN;
              m_warn  = warn_en && (m_val <= WARN_THRESH);
            end
          end
        end
        M_RUN: begin
          if (ps) begin
            m_state = M_PAUSED;
            m_warn  = 1'b0;
          end else if (tk) begin
            m_val = m_val - 1;
            if (m_val == 0) begin
              m_state = M_EXPIRED;
              m_pulse = 1'b1;
              m_warn  = 1'b0;
            end else if (warn_en && m_val <= WARN_THRESH) begin
              m_warn = (m_val + 1 > WARN_THRESH) ? 1'b1 : !m_warn;
            end else begin
              m_warn = 1'b0;
            end
          end
        end
        M_PAUSED: begin
          if (!ps && st) begin
            m_state = M_RUN;
            m_warn  = warn_en && (m_val <= WARN_THRESH);
          end
        end
        default: begin
        end
      endcase
    end
  endtask

  // Compare one observed field against its expected value.
  task automatic checkField(input string tag, input string field,
                            input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s.%s observed=%0d expected=%0d", tag, field, obs, exp);
    end
  endtask

  // Compare every DUT output against the reference model.
  task automatic checkOutput(input string tag);
    checkField(tag, "tens", 8'(tens), 8'(m_val / 10));
    checkField(tag, "units", 8'(units), 8'(m_val % 10));
    checkField(tag, "running", 8'(running), 8'(m_state == M_RUN));
    checkField(tag, "expired", 8'(expired), 8'(m_state == M_EXPIRED));
    checkField(tag, "timeout_pulse", 8'(timeout_pulse), 8'(m_pulse));
    checkField(tag, "warn", 8'(warn), 8'(m_warn));
  endtask

  // Drive one cycle of inputs, advance the model at the edge, then check.
  task automatic applyStimulus(input bit rst_n, input bit ld, input int lv,
                               input bit st, input bit ps, input bit tk,
                               input string tag);
    resetN   = rst_n;
    load     = ld;
    load_val = 7'(lv);
    start    = st;
    pause    = ps;
    one_sec  = tk;
    @(posedge clk);
    modelStep(rst_n, ld, lv, st, ps, tk);
    cycle++;
    if (tk) last_tick = cycle;
    #1;
    resetN  = 1'b1;
    load    = 1'b0;
    start   = 1'b0;
    pause   = 1'b0;
    one_sec = 1'b0;
    checkOutput(tag);
    if (timeout_pulse === 1'b1) pulse_seen++;
  endtask

  task automatic idleCycles(input int n, input string tag);
    for (int i = 0; i < n; i++) applyStimulus(1, 0, 0, 0, 0, 0, tag);
  endtask

  // Literal digit check independent of the model.
  task automatic checkDigits(input string tag, input int t, input int u);
    checkField(tag, "lit_tens", 8'(tens), 8'(t));
    checkField(tag, "lit_units", 8'(units), 8'(u));
  endtask

  initial begin
    int exp_warn[7];
    int base_pulses;
    bit r_rst, r_ld, r_st, r_ps, r_tk;
    int r_lv;

`ifdef COUNTDOWN_WARN_EN
    warn_en = 1'b1;
`else
    warn_en = 1'b0;
`endif
    m_state    = M_IDLE;
    m_val      = START_VAL;
    m_pulse    = 1'b0;
    m_warn     = 1'b0;
    pulse_seen = 0;
    cycle      = 0;
    last_tick  = -10;

    // Reset state.
    applyStimulus(0, 0, 0, 0, 0, 0, "reset");
    applyStimulus(0, 0, 0, 0, 0, 0, "reset");
    checkDigits("reset", 3, 0);

    // Full countdown from 12 with ticks 20 clocks apart.
    applyStimulus(1, 1, 12, 0, 0, 0, "load12");
    checkDigits("load12", 1, 2);
    applyStimulus(1, 0, 0, 1, 0, 0, "start12");
    checkField("start12", "lit_running", 8'(running), 8'd1);
    base_pulses = pulse_seen;
    for (int i = 1; i <= 12; i++) begin
      applyStimulus(1, 0, 0, 0, 0, 1, "count12");
      checkDigits("count12", (12 - i) / 10, (12 - i) % 10);
      checkField("count12", "lit_pulse", 8'(timeout_pulse), 8'(i == 12));
      idleCycles(19, "count12_gap");
    end
    checkField("count12", "lit_expired", 8'(expired), 8'd1);
    checkField("count12", "pulse_count", 8'(pulse_seen - base_pulses), 8'd1);

    // Saturation of an oversize load value.
    applyStimulus(1, 1, 120, 0, 0, 0, "load120");
    checkDigits("load120", 9, 9);
    checkField("load120", "lit_expired", 8'(expired), 8'd0);

    // Pause coincident with a tick, then ignored ticks, then resume.
    applyStimulus(1, 1, 10, 0, 0, 0, "pause_load");
    applyStimulus(1, 0, 0, 1, 0, 0, "pause_start");
    idleCycles(2, "pause_gap");
    applyStimulus(1, 0, 0, 0, 1, 1, "pause_tick");
    for (int i = 0; i < 3; i++) begin
      idleCycles(2, "pause_gap");
      applyStimulus(1, 0, 0, 0, 0, 1, "paused_tick");
    end
    checkDigits("paused", 1, 0);
    checkField("paused", "lit_running", 8'(running), 8'd0);
    applyStimulus(1, 0, 0, 1, 0, 0, "resume");
    idleCycles(2, "resume_gap");
    applyStimulus(1, 0, 0, 0, 0, 1, "resume_tick");
    checkDigits("resume_tick", 0, 9);

    // Start from zero expires at once; further inputs do not re-pulse.
    applyStimulus(1, 1, 0, 0, 0, 0, "zero_load");
    base_pulses = pulse_seen;
    applyStimulus(1, 0, 0, 1, 0, 0, "zero_start");
    checkField("zero_start", "lit_expired", 8'(expired), 8'd1);
    checkField("zero_start", "lit_pulse", 8'(timeout_pulse), 8'd1);
    applyStimulus(1, 0, 0, 1, 0, 0, "zero_restart");
    idleCycles(2, "zero_gap");
    applyStimulus(1, 0, 0, 0, 0, 1, "zero_tick");
    idleCycles(2, "zero_gap");
    applyStimulus(1, 0, 0, 0, 1, 0, "zero_pause");
    checkDigits("zero_hold", 0, 0);
    checkField("zero_hold", "pulse_count", 8'(pulse_seen - base_pulses), 8'd1);

    // Reset mid-countdown aborts without a pulse.
    applyStimulus(1, 1, 7, 0, 0, 0, "rst_load");
    applyStimulus(1, 0, 0, 1, 0, 0, "rst_start");
    idleCycles(2, "rst_gap");
    applyStimulus(0, 0, 0, 0, 0, 0, "rst_mid");
    checkDigits("rst_mid", 3, 0);
    checkField("rst_mid", "lit_running", 8'(running), 8'd0);
    checkField("rst_mid", "lit_pulse", 8'(timeout_pulse), 8'd0);

    // Warning window walk from 07 down to 00.
    exp_warn = '{0, 1, 0, 1, 0, 1, 0};
    applyStimulus(1, 1, 7, 0, 0, 0, "warn_load");
    applyStimulus(1, 0, 0, 1, 0, 0, "warn_start");
    checkField("warn_start", "lit_warn", 8'(warn), 8'd0);
    for (int i = 0; i < 7; i++) begin
      idleCycles(3, "warn_gap");
      applyStimulus(1, 0, 0, 0, 0, 1, "warn_tick");
      checkField("warn_tick", "lit_warn", 8'(warn), warn_en ? 8'(exp_warn[i]) : 8'd0);
    end

    // Randomized phase against the model.
    for (int n = 0; n < 4000; n++) begin
      r_rst = ($urandom_range(0, 299) != 0);
      r_ld  = ($urandom_range(0, 39) == 0);
      r_lv  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 127))
                                          : int'($urandom_range(0, 12));
      r_ps  = ($urandom_range(0, 29) == 0);
      r_st  = ($urandom_range(0, 11) == 0);
      r_tk  = (cycle + 1 - last_tick >= 2) && ($urandom_range(0, 2) == 0);
      if (r_tk) r_st = 1'b0;
      applyStimulus(r_rst, r_ld, r_lv, r_st, r_ps, r_tk, "random");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
